// File: rtl/apb_pkg.sv
// Shared definitions for the APB command path.
//   arb_state_t : request arbiter state encoding
//   APB_AW/DW   : default address/data widths, common with apb_master
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } arb_state_t;

  localparam int unsigned APB_AW = 8;
  localparam int unsigned APB_DW = 8;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req     : request vector, one bit per requester
//   ptr     : index where the search starts (wraps at NREQ)
//   gnt     : one-hot grant for the first set request at or above ptr
//   gnt_idx : index of the granted requester
//   any     : at least one request is set
module rr_picker #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            any
);

  logic [IW-1:0] w_idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = IW'((32'(ptr) + k) % NREQ);
      if (!any && req[w_idx]) begin
        any          = 1'b1;
        gnt[w_idx]   = 1'b1;
        gnt_idx      = w_idx;
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one apb_master between NREQ requesters.
//   PCLK/PRESET            : clock, synchronous active-high reset
//   req_valid/write/addr/wdata : per-requester requests (packed buses)
//   req_ready              : one-hot accept, combinational, IDLE only
//   rsp_valid/rsp_rdata    : one-hot completion pulse and read data
//   start_write/start_read : one-cycle command pulse to the master
//   addr/wdata             : latched command address/data
//   rdata/done             : master read data and completion pulse
//   busy                   : not IDLE
//   grant_id               : current or last winner
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = APB_AW,
  parameter int unsigned DW   = APB_DW,
  parameter int unsigned IW   = $clog2(NREQ)
) (
  input  logic               PCLK,
  input  logic               PRESET,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_rdata,
  output logic               start_write,
  output logic               start_read,
  output logic [AW-1:0]      addr,
  output logic [DW-1:0]      wdata,
  input  logic [DW-1:0]      rdata,
  input  logic               done,
  output logic               busy,
  output logic [IW-1:0]      grant_id
);

  arb_state_t    r_state;
  arb_state_t    w_next;

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_grant_id;
  logic          r_write;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_gnt_idx;
  logic            w_any;

  rr_picker #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_picker (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    req_ready   = '0;
    start_write = 1'b0;
    start_read  = 1'b0;
    rsp_valid   = '0;
    busy        = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        req_ready = w_gnt;
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        start_write = r_write;
        start_read  = !r_write;
        w_next      = WAIT;
      end
      WAIT: begin
        if (done) w_next = GAP;
      end
      GAP: begin
        rsp_valid[r_grant_id] = 1'b1;
        w_next                = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_ptr      <= '0;
      r_grant_id <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant_id <= w_gnt_idx;
            r_write    <= req_write[w_gnt_idx];
            r_addr     <= req_addr[w_gnt_idx*AW +: AW];
            r_wdata    <= req_wdata[w_gnt_idx*DW +: DW];
          end
        end
        ISSUE: begin
          r_ptr <= (r_grant_id == IW'(NREQ-1)) ? '0 : r_grant_id + IW'(1);
        end
        WAIT: begin
          // Writes report zero so requesters never see stale bus data.
          if (done) r_rdata <= r_write ? '0 : rdata;
        end
        default: ;
      endcase
    end
  end

  assign addr      = r_addr;
  assign wdata     = r_wdata;
  assign rsp_rdata = r_rdata;
  assign grant_id  = r_grant_id;

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Shares the single `apb_master` transaction engine between `NREQ` independent requesters. Each requester presents a read or write request; the block picks one by round-robin and issues it as a one-cycle `start_write`/`start_read` pulse with its address and write data. It then waits for the master's `done` pulse and returns the completion and read data to the requester that won. It sits directly above `apb_master` and drives that module's command inputs.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `AW`, 8: address width. Matches the master's `addr`.
- `DW`, 8: data width. Matches the master's `wdata`/`rdata`.

- `PCLK` in 1: sole clock, rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_write` in NREQ: 1 = write, 0 = read.
- `req_addr` in NREQ*AW: packed addresses. Requester i owns bits [i*AW +: AW].
- `req_wdata` in NREQ*DW: packed write data, same packing.
- `req_ready` out NREQ: one-hot accept. Combinational.
- `rsp_valid` out NREQ: one-hot completion pulse.
- `rsp_rdata` out DW: read data, valid while `rsp_valid` is non-zero.
- `start_write` out 1: command pulse to the master.
- `start_read` out 1: command pulse to the master.
- `addr` out AW: command address to the master.
- `wdata` out DW: command write data to the master.
- `rdata` in DW: master read data.
- `done` in 1: master completion pulse.
- `busy` out 1: high whenever the state is not IDLE.
- `grant_id` out $clog2(NREQ): index of the current or last winner.

## Operation
- **States** IDLE → ISSUE → WAIT → GAP → IDLE.
- **IDLE**
  - The round-robin picker takes the first set `req_valid` bit, searching upward from `ptr` and wrapping at NREQ.
  - `req_ready[winner]` = 1 in the same cycle.
  - Handshake is `req_valid & req_ready` at the clock edge. On it, the block latches `grant_id`, `req_write`, the winner's address and the winner's write data, then moves to ISSUE.
  - No request: stay in IDLE.
- **ISSUE** (exactly 1 cycle)
  - Drive `start_write` = latched write flag and `start_read` = !latched write flag.
  - Drive `addr`/`wdata` from the latched values.
  - Update `ptr` to (grant_id+1) mod NREQ.
  - Go to WAIT.
- **WAIT**
  - Both start pulses low. `addr`/`wdata` hold their latched values.
  - On `done` = 1, capture `rdata` (for a write, capture 0 instead) and go to GAP.
- **GAP** (exactly 1 cycle)
  - `rsp_valid[grant_id]` = 1 and `rsp_rdata` = captured value.
  - No start pulse is issued, which gives the master time to return to its idle state.
  - Go to IDLE.
- **`req_ready` rule**: zero in every state except IDLE, and never more than one bit set.
- **Requester rule**: a requester holds `req_valid`, `req_write`, `req_addr` and `req_wdata` stable until it sees `req_ready`. It may drop `req_valid` before being granted.
- **`done` outside WAIT**: ignored.
- **Request changes in non-IDLE states**: have no effect. Requests are only sampled in IDLE.
- **Reset values** (at the first edge with `PRESET` = 1):
  - state = IDLE, `ptr` = 0, `grant_id` = 0.
  - `start_write` = `start_read` = 0, `addr` = 0, `wdata` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `busy` = 0.
  - `req_ready` follows from IDLE, so it may go high in the first cycle after reset.
- **Reset mid-transaction**: the in-flight transaction is dropped and no `rsp_valid` is issued. The master is reset from the same reset source at the same time.

## Timing
- Edge t0 is the handshake edge.
  - Start pulse: high for cycle t0..t0+1.
  - With a zero-wait slave, `done` arrives 2 cycles after the start pulse.
  - `rsp_valid`: high for the cycle after the `done` cycle.
- Minimum spacing between start pulses: ISSUE + WAIT (≥ 2 cycles) + GAP + IDLE (1 cycle).
- Slave wait states add cycles 1:1 in WAIT. There is no timeout; a slave that never completes keeps the block in WAIT until reset.
- Fairness: with all requesters permanently valid, the grant order is 0, 1, …, NREQ-1, 0, …. No requester waits more than NREQ-1 transactions.

## Structure
- **Shared package `apb_pkg`**:
  - `arb_state_t` enum: IDLE, ISSUE, WAIT, GAP.
  - Default AW/DW constants, shared with `apb_master`.
- **Sub-module `rr_picker`**:
  - Purely combinational. Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt`, `gnt_idx`, `any`.
  - The picker is reused by other shared-resource blocks.

## Test plan
- **Single write**: requester 2 writes addr 0x3C with data 0xA5 to a zero-wait slave. Expect `req_ready` = 0b0100 for one cycle, one `start_write` pulse with `addr` = 0x3C and `wdata` = 0xA5, then `rsp_valid` = 0b0100 with `rsp_rdata` = 0x00.
- **Read with 3 wait states**: requester 0 reads addr 0x10; slave returns 0x5A after PREADY was held low for 3 cycles. Expect exactly one `start_read` pulse, `busy` high throughout, and `rsp_valid[0]` = 1 with `rsp_rdata` = 0x5A, arriving 3 cycles later than in the zero-wait case.
- **Round-robin fairness**: all 4 requesters held valid. Expect grants in the order 0, 1, 2, 3, 0, 1 and never two start pulses within 4 cycles.
- **Pointer wrap**: last grant was 3; requesters 0 and 1 become valid simultaneously. Expect requester 0 to win, then requester 1.
- **Reset mid-WAIT**: assert `PRESET` during WAIT. Expect all outputs to reach their reset values at the next edge, no `rsp_valid` for the aborted transaction, and a fresh request then served with a grant from `ptr` = 0.
- **Stray `done`**: pulse `done` while in IDLE. Expect no `rsp_valid` and no state change.
